// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer and its
// companion deserializer: FSM state encodings and the bit-counter width.
package serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Counter width needed to count 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 32'd2) ? 32'd1 : 32'($clog2(w));
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-MODULUS counter with synchronous clear, count enable and a
// terminal-count flag. Shared by the serializer and the deserializer.
module piso_bit_counter
  import serializer_pkg::*;
#(
  parameter int unsigned MODULUS = 8,
  parameter int unsigned CW      = cnt_width(MODULUS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  localparam logic [CW-1:0] LP_LAST = CW'(MODULUS - 32'd1);

  logic [CW-1:0] r_count;

  // Count register: clear has priority, wraps to zero after the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_en) begin
      if (r_count == LP_LAST) begin
        r_count <= {CW{1'b0}};
      end else begin
        r_count <= r_count + CW'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LP_LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding the serial shift-register chain.
// A WIDTH-bit word is accepted over load_valid/load_ready and emitted one bit
// per clock on ser_out, qualified by ser_valid, with done on the final bit.
// Back-to-back words stream without a gap.
// Optional feature macro: PIPO_SER_PARITY_EN appends an even-parity bit to
// every frame (frame becomes WIDTH+1 bits, done/load_ready move to it).
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] LP_LAST_M1 = CW'(WIDTH - 32'd2);
`ifdef PIPO_SER_PARITY_EN
  localparam bit            LP_PAR_EN  = 1'b1;
`else
  localparam bit            LP_PAR_EN  = 1'b0;
`endif

`ifdef PIPO_SER_PARITY_EN
  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_sreg_rest;
  logic             w_load_first;
  logic             w_sreg_first;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_ser_out_nxt;
  logic             w_ser_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_ready;
  logic             w_accept;
  logic             w_cnt_en;
  logic [CW-1:0]    w_cnt;
  logic             w_tc;
`ifdef PIPO_SER_PARITY_EN
  logic             r_par;
`endif

  piso_bit_counter #(
    .MODULUS (WIDTH),
    .CW      (CW)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_en    (w_cnt_en),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

  assign w_cnt_en   = (r_state == ST_SHIFT);
  assign w_accept   = load_valid & w_ready;
  assign load_ready = w_ready;

  // Ready decode from state and counter only: idle, or the frame's final bit.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE:   w_ready = 1'b1;
      ST_SHIFT:  w_ready = w_tc & ~LP_PAR_EN;
      ST_PARITY: w_ready = LP_PAR_EN;
      default:   w_ready = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!w_tc) begin
          w_state_nxt = ST_SHIFT;
        end else if (LP_PAR_EN) begin
          w_state_nxt = ST_PARITY;
        end else if (w_accept) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PARITY: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit selection for the configured order: the bit leaving now and the rest.
  always_comb begin
    w_load_first = 1'b0;
    w_sreg_first = 1'b0;
    w_load_rest  = {WIDTH{1'b0}};
    w_sreg_rest  = {WIDTH{1'b0}};
    if (LSB_FIRST) begin
      w_load_first = load_data[0];
      w_load_rest  = {1'b0, load_data[WIDTH-1:1]};
      w_sreg_first = r_sreg[0];
      w_sreg_rest  = {1'b0, r_sreg[WIDTH-1:1]};
    end else begin
      w_load_first = load_data[WIDTH-1];
      w_load_rest  = {load_data[WIDTH-2:0], 1'b0};
      w_sreg_first = r_sreg[WIDTH-1];
      w_sreg_rest  = {r_sreg[WIDTH-2:0], 1'b0};
    end
  end

  // Output decode: next values of the registered outputs from the next state.
  always_comb begin
    w_ser_out_nxt   = 1'b0;
    w_ser_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    if (w_accept) begin
      w_sreg_nxt = w_load_rest;
    end else if (r_state == ST_SHIFT) begin
      w_sreg_nxt = w_sreg_rest;
    end else begin
      w_sreg_nxt = r_sreg;
    end
    case (w_state_nxt)
      ST_SHIFT: begin
        w_ser_valid_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
        w_ser_out_nxt   = w_accept ? w_load_first : w_sreg_first;
        // Final data bit is the one following count WIDTH-2.
        w_done_nxt      = ~LP_PAR_EN & ~w_accept &
                          (r_state == ST_SHIFT) & (w_cnt == LP_LAST_M1);
      end
`ifdef PIPO_SER_PARITY_EN
      ST_PARITY: begin
        w_ser_valid_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
        w_ser_out_nxt   = r_par;
        w_done_nxt      = 1'b1;
      end
`endif
      default: begin
        w_ser_out_nxt   = 1'b0;
        w_ser_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
      end
    endcase
  end

  // Shift register and parity capture; load_data sampled only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= {WIDTH{1'b0}};
`ifdef PIPO_SER_PARITY_EN
      r_par  <= 1'b0;
`endif
    end else begin
      r_sreg <= w_sreg_nxt;
`ifdef PIPO_SER_PARITY_EN
      if (w_accept) begin
        r_par <= even_parity(load_data);
      end else begin
        r_par <= r_par;
      end
`endif
    end
  end

  // Registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
